demux1x2_reg: RTL

DEMUX1X2_REG -- requirements
Module: demux1x2_reg

---
 rtl/demux1x2_reg_pkg.sv | 12 +
 rtl/demux1x2_reg_registrador_n.sv | 26 ++
 rtl/demux1x2_reg.sv | 128 ++++++++++++
 3 files changed

// File: rtl/demux1x2_reg_pkg.sv
// Shared definitions for demux1x2_reg: FSM state encodings and the default data width.
package demux1x2_reg_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    ESCREVE = 2'b01,
    PRONTO  = 2'b10
  } estado_t;

  localparam int LARGURA_PADRAO = 4;

endpackage

// File: rtl/demux1x2_reg_registrador_n.sv
// Generic N-bit register with synchronous clear (dominant) and load enable.
module registrador_n
  import demux1x2_reg_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               clk_i,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [LARGURA-1:0] d_i,
  output logic [LARGURA-1:0] q_o
);

  logic [LARGURA-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/demux1x2_reg.sv
// Registered 1-to-2 demultiplexer driven by a three-state load FSM.
// Optional macro DEMUX_PINGPONG_EN: ignore SEL and alternate destinations OUT0, OUT1, ...
module demux1x2_reg
  import demux1x2_reg_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [LARGURA-1:0] D,
  input  logic               SEL,
  input  logic               carrega,
  input  logic               limpa,
  output logic [LARGURA-1:0] OUT0,
  output logic [LARGURA-1:0] OUT1,
  output logic               valido0,
  output logic               valido1,
  output logic               ocupado,
  output logic               pronto,
  output logic [3:0]         contagem
);

  estado_t            estado_q, estado_d;
  logic [LARGURA-1:0] dado_q;
  logic               destino;
  logic               aceita;
  logic               escreve;
  logic               limpa_tudo;
  logic               valido0_q, valido1_q;
  logic [3:0]         contagem_q;

  // reset dominates limpa, limpa dominates any FSM activity
  assign limpa_tudo = reset | limpa;
  assign aceita     = (estado_q == OCIOSO) && carrega && !limpa;
  assign escreve    = (estado_q == ESCREVE) && !limpa;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d = OCIOSO;
    if (!limpa) begin
      case (estado_q)
        OCIOSO:  estado_d = carrega ? ESCREVE : OCIOSO;
        ESCREVE: estado_d = PRONTO;
        PRONTO:  estado_d = OCIOSO;
        default: estado_d = OCIOSO;
      endcase
    end
  end

`ifdef DEMUX_PINGPONG_EN
  logic alterna_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      dado_q <= '0;
    end else if (aceita) begin
      dado_q <= D;
    end
  end

  // destination is fixed for the whole write; it flips only once the write lands
  always_ff @(posedge clock) begin
    if (limpa_tudo) begin
      alterna_q <= 1'b0;
    end else if (escreve) begin
      alterna_q <= ~alterna_q;
    end
  end

  assign destino = alterna_q;
`else
  logic sel_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      dado_q <= '0;
      sel_q  <= 1'b0;
    end else if (aceita) begin
      dado_q <= D;
      sel_q  <= SEL;
    end
  end

  assign destino = sel_q;
`endif

  registrador_n #(.LARGURA(LARGURA)) u_reg_out0 (
    .clk_i (clock),
    .clr_i (limpa_tudo),
    .en_i  (escreve && !destino),
    .d_i   (dado_q),
    .q_o   (OUT0)
  );

  registrador_n #(.LARGURA(LARGURA)) u_reg_out1 (
    .clk_i (clock),
    .clr_i (limpa_tudo),
    .en_i  (escreve && destino),
    .d_i   (dado_q),
    .q_o   (OUT1)
  );

  always_ff @(posedge clock) begin
    if (limpa_tudo) begin
      valido0_q  <= 1'b0;
      valido1_q  <= 1'b0;
      contagem_q <= 4'd0;
    end else if (escreve) begin
      valido0_q  <= valido0_q | !destino;
      valido1_q  <= valido1_q | destino;
      contagem_q <= contagem_q + 4'd1;
    end
  end

  assign valido0  = valido0_q;
  assign valido1  = valido1_q;
  assign contagem = contagem_q;
  assign ocupado  = (estado_q == ESCREVE) || (estado_q == PRONTO);
  assign pronto   = (estado_q == PRONTO);

endmodule
